// File: rtl/dot_product_stream.sv
// dot_product_stream: handshaked signed dot product over N/LANES beats, with vector chaining.
// Define DOTP_SAT_EN for saturating accumulation with a sticky ovf; otherwise adds wrap and ovf stays 0.
module dot_product_stream #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int OUT_W = 2*WIDTH+4
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [N*WIDTH-1:0]      A,
  input  logic [N*WIDTH-1:0]      B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dot_out,
  output logic                    ovf
);
  localparam int BEATS = N / LANES;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int SW    = OUT_W + 2*WIDTH + $clog2(LANES) + 2;
  localparam logic signed [SW-1:0] MAXV = SW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                  state;
  logic [N*WIDTH-1:0]      a_r, b_r;
  logic                    last_r, ovf_r, sat_hit;
  logic [BW-1:0]           beat;
  logic signed [OUT_W-1:0] acc, acc_next;
  logic signed [SW-1:0]    lane_sum, sum;
  logic signed [WIDTH-1:0] ae, be;
  logic signed [2*WIDTH-1:0] p;
  assign in_ready = rst && state == IDLE;
  assign ovf      = ovf_r;
  always_comb begin
    lane_sum = '0;
    ae = '0;
    be = '0;
    p  = '0;
    for (int l = 0; l < LANES; l++) begin
      ae = a_r[(int'(beat)*LANES + l)*WIDTH +: WIDTH];
      be = b_r[(int'(beat)*LANES + l)*WIDTH +: WIDTH];
      p  = (2*WIDTH)'(ae) * (2*WIDTH)'(be);
      lane_sum = lane_sum + SW'(p);
    end
    sum = SW'(acc) + lane_sum;
  end
`ifdef DOTP_SAT_EN
  always_comb begin
    sat_hit  = sum > MAXV || sum < MINV;
    acc_next = sum > MAXV ? MAXV[OUT_W-1:0] : sum < MINV ? MINV[OUT_W-1:0] : sum[OUT_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^{sum[SW-1:OUT_W], MAXV, MINV};
  assign sat_hit   = 1'b0;
  assign acc_next  = sum[OUT_W-1:0];
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      last_r    <= 1'b0;
      beat      <= '0;
      acc       <= '0;
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      dot_out   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r    <= A;
          b_r    <= B;
          last_r <= in_last;
          beat   <= '0;
          state  <= RUN;
        end
        RUN: begin
          acc   <= acc_next;
          ovf_r <= ovf_r | sat_hit;
          beat  <= beat + 1'b1;
          // accumulator and ovf persist into IDLE when chaining
          if (beat == BW'(BEATS-1)) begin
            state     <= last_r ? DONE : IDLE;
            out_valid <= last_r;
            dot_out   <= last_r ? acc_next : dot_out;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
          ovf_r     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_stream.sv
// tb_dot_product_stream: directed checks of dot_product_stream (default, OUT_W=16 and LANES=8 builds).
module tb_dot_product_stream;
  logic clk, rst, il, iv0, iv1, iv2, or0, or_hi;
  logic [63:0] A, B;
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, ovf0, ovf1, ovf2;
  logic signed [19:0] dot0, dot2;
  logic signed [15:0] dot1;
  int total, passed;

  dot_product_stream dut0 (.clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .in_last(il),
    .A(A), .B(B), .out_valid(ov0), .out_ready(or0), .dot_out(dot0), .ovf(ovf0));
  dot_product_stream #(.OUT_W(16)) dut16 (.clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1),
    .in_last(il), .A(A), .B(B), .out_valid(ov1), .out_ready(or_hi), .dot_out(dot1), .ovf(ovf1));
  dot_product_stream #(.LANES(8)) dut8 (.clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2),
    .in_last(il), .A(A), .B(B), .out_valid(ov2), .out_ready(or_hi), .dot_out(dot2), .ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_all(input int av, input int bv);
    for (int i = 0; i < 8; i++) begin
      A[i*8 +: 8] = 8'(av);
      B[i*8 +: 8] = 8'(bv);
    end
  endtask

  task automatic send0(input logic last);
    for (int i = 0; i < 20 && rdy0 !== 1'b1; i++) @(negedge clk);
    il = last;
    iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
  endtask

  task automatic wait_ov0();
    for (int i = 0; i < 20 && ov0 !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; iv0 = 0; iv1 = 0; iv2 = 0; il = 0; or0 = 1; or_hi = 1; A = '0; B = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (rdy0 !== 1'b0) $display("FAIL rst_in_ready got %0b exp 0", rdy0); else passed++;
    total++; if (ov0 !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", ov0); else passed++;
    total++; if (dot0 !== 20'sd0) $display("FAIL rst_dot got %0d exp 0", dot0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL rst_ovf got %0b exp 0", ovf0); else passed++;
    rst = 1'b1;
    #1;
    total++; if (rdy0 !== 1'b1) $display("FAIL rel_in_ready got %0b exp 1", rdy0); else passed++;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_all(3, -2);
    or0 = 1'b1;
    send0(1'b1);
    for (int i = 0; i < 4; i++) begin
      total++; if (ov0 !== 1'b0) $display("FAIL lat_ov cyc %0d got %0b exp 0", i, ov0); else passed++;
      total++; if (rdy0 !== 1'b0) $display("FAIL busy_rdy cyc %0d got %0b exp 0", i, rdy0); else passed++;
      @(negedge clk);
    end
    total++; if (ov0 !== 1'b1) $display("FAIL single_ov got %0b exp 1", ov0); else passed++;
    total++; if (dot0 !== -20'sd48) $display("FAIL single_dot got %0d exp -48", dot0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL single_ovf got %0b exp 0", ovf0); else passed++;
    @(negedge clk);
    total++; if (rdy0 !== 1'b1) $display("FAIL single_rdy_after got %0b exp 1", rdy0); else passed++;
  endtask

  task automatic test_chain();
    int seen;
    for (int i = 0; i < 8; i++) begin
      A[i*8 +: 8] = 8'(i + 1);
      B[i*8 +: 8] = 8'd1;
    end
    or0 = 1'b1;
    seen = 0;
    send0(1'b0);
    for (int i = 0; i < 6; i++) begin
      if (ov0 === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("FAIL chain_early_ov got %0d exp 0", seen); else passed++;
    send0(1'b1);
    wait_ov0();
    total++; if (dot0 !== 20'sd72) $display("FAIL chain_dot got %0d exp 72", dot0); else passed++;
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ov0 === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("FAIL chain_extra_ov got %0d exp 0", seen); else passed++;
  endtask

  task automatic test_backpressure();
    set_all(3, -2);
    or0 = 1'b0;
    send0(1'b1);
    wait_ov0();
    set_all(5, 5);
    il = 1'b1;
    iv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (ov0 !== 1'b1) $display("FAIL bp_ov cyc %0d got %0b exp 1", i, ov0); else passed++;
      total++; if (dot0 !== -20'sd48) $display("FAIL bp_dot cyc %0d got %0d exp -48", i, dot0); else passed++;
      total++; if (rdy0 !== 1'b0) $display("FAIL bp_rdy cyc %0d got %0b exp 0", i, rdy0); else passed++;
      @(negedge clk);
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    @(negedge clk);
    total++; if (rdy0 !== 1'b1) $display("FAIL bp_rdy_after got %0b exp 1", rdy0); else passed++;
    total++; if (ov0 !== 1'b0) $display("FAIL bp_ov_after got %0b exp 0", ov0); else passed++;
  endtask

  task automatic test_back_to_back();
    int rise[$];
    logic prev;
    set_all(3, -2);
    il = 1'b1;
    or0 = 1'b1;
    prev = ov0;
    @(negedge clk);
    iv0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ov0 === 1'b1 && prev !== 1'b1) begin
        rise.push_back(i);
        total++; if (dot0 !== -20'sd48) $display("FAIL b2b_dot got %0d exp -48", dot0); else passed++;
      end
      prev = ov0;
    end
    iv0 = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (rise.size() < 2) $display("FAIL b2b_results got %0d exp 2", rise.size());
    else if (rise[1] - rise[0] !== 6) $display("FAIL b2b_interval got %0d exp 6", rise[1] - rise[0]);
    else passed++;
  endtask

  task automatic test_overflow();
    int e_dot;
    logic e_ovf;
`ifdef DOTP_SAT_EN
    e_dot = 32767; e_ovf = 1'b1;
`else
    e_dot = 0; e_ovf = 1'b0;
`endif
    set_all(-128, -128);
    il = 1'b1;
    @(negedge clk);
    iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    for (int i = 0; i < 20 && ov1 !== 1'b1; i++) @(negedge clk);
    total++; if (ov1 !== 1'b1) $display("FAIL ovf_ov got %0b exp 1", ov1); else passed++;
    total++; if (int'(dot1) !== e_dot) $display("FAIL ovf_dot got %0d exp %0d", dot1, e_dot); else passed++;
    total++; if (ovf1 !== e_ovf) $display("FAIL ovf_flag got %0b exp %0b", ovf1, e_ovf); else passed++;
    @(negedge clk);
    total++; if (ovf1 !== 1'b0) $display("FAIL ovf_clear got %0b exp 0", ovf1); else passed++;
  endtask

  task automatic test_reset_mid();
    set_all(3, -2);
    or0 = 1'b1;
    send0(1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (ov0 !== 1'b0) $display("FAIL rrun_ov got %0b exp 0", ov0); else passed++;
    total++; if (rdy0 !== 1'b0) $display("FAIL rrun_rdy got %0b exp 0", rdy0); else passed++;
    @(negedge clk);
    rst = 1'b1;
    set_all(1, 1);
    send0(1'b1);
    wait_ov0();
    total++; if (dot0 !== 20'sd8) $display("FAIL rrun_next_dot got %0d exp 8", dot0); else passed++;
    @(negedge clk);
    set_all(3, -2);
    or0 = 1'b0;
    send0(1'b1);
    wait_ov0();
    #2 rst = 1'b0;
    #1;
    total++; if (ov0 !== 1'b0) $display("FAIL rdone_ov got %0b exp 0", ov0); else passed++;
    total++; if (dot0 !== 20'sd0) $display("FAIL rdone_dot got %0d exp 0", dot0); else passed++;
    @(negedge clk);
    rst = 1'b1;
    or0 = 1'b1;
    set_all(1, 1);
    send0(1'b1);
    wait_ov0();
    total++; if (dot0 !== 20'sd8) $display("FAIL rdone_next_dot got %0d exp 8", dot0); else passed++;
    @(negedge clk);
  endtask

  task automatic test_lanes8();
    int av, bv, ref_sum;
    for (int t = 0; t < 3; t++) begin
      ref_sum = 0;
      for (int i = 0; i < 8; i++) begin
        av = int'($urandom_range(99)) - 50;
        bv = int'($urandom_range(99)) - 50;
        A[i*8 +: 8] = 8'(av);
        B[i*8 +: 8] = 8'(bv);
        ref_sum += av * bv;
      end
      il = 1'b1;
      @(negedge clk);
      iv2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv2 = 1'b0;
      total++; if (ov2 !== 1'b0) $display("FAIL l8_early_ov got %0b exp 0", ov2); else passed++;
      @(negedge clk);
      total++; if (ov2 !== 1'b1) $display("FAIL l8_ov got %0b exp 1", ov2); else passed++;
      total++; if (int'(dot2) !== ref_sum) $display("FAIL l8_dot got %0d exp %0d", dot2, ref_sum); else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_single();
    test_chain();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_lanes8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
